// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard unit.
//   fwd_sel_e : ALU operand forward select (register file / writeback / memory)
//   REG_ZERO  : architectural zero register index (never forwarded, never stalls)
//   fwd_pick  : priority resolution of M/W forwarding hits
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int REG_ZERO = 0;

  // The M-stage result is younger than the W-stage result, so it wins when both match.
  function automatic fwd_sel_e fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_MEM;
    else if (hit_w) return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_rd_pipe.sv
// hazard_rd_pipe: E/M/W register-address chain shadowing the controller pipeline.
//   clk, reset             : clock, asynchronous active-high reset
//   flush_e                : synchronous clear of the E-stage addresses (bubble insert)
//   rs1_d, rs2_d, rd_d     : decode-stage addresses
//   rs1_e, rs2_e, rd_e     : execute-stage addresses
//   rd_m, rd_w             : memory / writeback destination addresses
// No stage ever stalls; a load-use stall is realised by flushing E while
// the front end holds, which keeps this chain aligned with the controller.
module hazard_rd_pipe
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_e,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_d,
  output logic [REG_W-1:0] rs1_e,
  output logic [REG_W-1:0] rs2_e,
  output logic [REG_W-1:0] rd_e,
  output logic [REG_W-1:0] rd_m,
  output logic [REG_W-1:0] rd_w
);

  localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(REG_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_e <= ZERO_ADDR;
      rs2_e <= ZERO_ADDR;
      rd_e  <= ZERO_ADDR;
      rd_m  <= ZERO_ADDR;
      rd_w  <= ZERO_ADDR;
    end else begin
      if (flush_e) begin
        rs1_e <= ZERO_ADDR;
        rs2_e <= ZERO_ADDR;
        rd_e  <= ZERO_ADDR;
      end else begin
        rs1_e <= rs1_d;
        rs2_e <= rs2_d;
        rd_e  <= rd_d;
      end
      rd_m <= rd_e;
      rd_w <= rd_m;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use stall and control-flush logic for a
// five-stage pipeline; consumer of the pipelined controller's hazard outputs.
//   clk, reset                 : clock, asynchronous active-high reset
//   Rs1D, Rs2D, RdD            : decode-stage register addresses
//   ResultSrcEb0               : E-stage instruction is a load
//   PCSrcE                     : E-stage branch taken / jump
//   RegWriteM, RegWriteW       : M / W stage write the register file
//   ForwardAE, ForwardBE       : ALU operand selects (00 RF, 01 W, 10 M)
//   StallF, StallD             : hold PC and F/D register
//   FlushD, FlushE             : clear F/D and D/E registers (FlushE also to controller)
//   StallCnt, FlushCnt         : load-use stall cycles / control flushes
// Build option HAZARD_PERF_EN: when defined, StallCnt and FlushCnt are live
// wrapping counters; otherwise they are tied to zero.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] RdD,
  input  logic             ResultSrcEb0,
  input  logic             PCSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(REG_ZERO);

  logic [REG_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic             lw_stall;
  logic             flush_e;

  hazard_rd_pipe #(.REG_W(REG_W)) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush_e (flush_e),
    .rs1_d   (Rs1D),
    .rs2_d   (Rs2D),
    .rd_d    (RdD),
    .rs1_e   (rs1_e),
    .rs2_e   (rs2_e),
    .rd_e    (rd_e),
    .rd_m    (rd_m),
    .rd_w    (rd_w)
  );

  // Load in E whose destination is read by the instruction in D.
  assign lw_stall = ResultSrcEb0 && (rd_e != ZERO_ADDR) &&
                    ((Rs1D == rd_e) || (Rs2D == rd_e));

  // A taken branch also flushes E, discarding any instruction held by a
  // simultaneous load-use stall.
  assign flush_e = lw_stall || PCSrcE;

  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign FlushD = PCSrcE;
  assign FlushE = flush_e;

  assign ForwardAE = fwd_pick(RegWriteM && (rs1_e != ZERO_ADDR) && (rs1_e == rd_m),
                              RegWriteW && (rs1_e != ZERO_ADDR) && (rs1_e == rd_w));
  assign ForwardBE = fwd_pick(RegWriteM && (rs2_e != ZERO_ADDR) && (rs2_e == rd_m),
                              RegWriteW && (rs2_e != ZERO_ADDR) && (rs2_e == rd_w));

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lw_stall) stall_cnt <= stall_cnt + 1'b1;
      if (PCSrcE)   flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] Rs1D, Rs2D, RdD;
  logic             ResultSrcEb0, PCSrcE, RegWriteM, RegWriteW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .RdD          (RdD),
    .ResultSrcEb0 (ResultSrcEb0),
    .PCSrcE       (PCSrcE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  always #5 clk = ~clk;

  // Reference model: the in-flight instructions, described by their addresses.
  typedef struct {
    int rs1;
    int rs2;
    int rd;
  } inst_t;

  typedef struct {
    int fa;
    int fb;
    int stall;
    int fd;
    int fe;
    longint sc;
    longint fc;
  } exp_t;

  exp_t   sbq[$];
  inst_t  ex_inst;
  int     mem_rd, wb_rd;
  longint n_stall, n_flush;

  int checks = 0;
  int errors = 0;

  // Youngest older producer of src wins; x0 is never a dependency.
  function automatic int fwd_of(int src, int wm, int ww);
    if (src == 0) return 0;
    if (wm != 0 && src == mem_rd) return 2;
    if (ww != 0 && src == wb_rd) return 1;
    return 0;
  endfunction

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs at posedge+1, push the expected response and
  // advance the model to the state the next edge produces.
  task automatic issue(int rst, int rs1, int rs2, int rd, int ld, int pcs, int wm, int ww);
    exp_t  e;
    int    stall;
    @(posedge clk);
    #1;
    reset        = (rst != 0);
    Rs1D         = REG_W'(rs1);
    Rs2D         = REG_W'(rs2);
    RdD          = REG_W'(rd);
    ResultSrcEb0 = (ld != 0);
    PCSrcE       = (pcs != 0);
    RegWriteM    = (wm != 0);
    RegWriteW    = (ww != 0);
    if (rst != 0) begin
      ex_inst = '{0, 0, 0};
      mem_rd  = 0;
      wb_rd   = 0;
      n_stall = 0;
      n_flush = 0;
    end
    stall = (ld != 0 && ex_inst.rd != 0 && (rs1 == ex_inst.rd || rs2 == ex_inst.rd)) ? 1 : 0;
    e.fa    = fwd_of(ex_inst.rs1, wm, ww);
    e.fb    = fwd_of(ex_inst.rs2, wm, ww);
    e.stall = stall;
    e.fd    = pcs;
    e.fe    = (stall != 0 || pcs != 0) ? 1 : 0;
`ifdef HAZARD_PERF_EN
    e.sc = n_stall % (64'd1 << CNT_W);
    e.fc = n_flush % (64'd1 << CNT_W);
`else
    e.sc = 0;
    e.fc = 0;
`endif
    sbq.push_back(e);
    if (rst == 0) begin
      wb_rd  = mem_rd;
      mem_rd = ex_inst.rd;
      if (e.fe != 0) ex_inst = '{0, 0, 0};
      else           ex_inst = '{rs1, rs2, rd};
      n_stall += stall;
      n_flush += pcs;
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("ForwardAE", ForwardAE, e.fa);
      check("ForwardBE", ForwardBE, e.fb);
      check("StallF", StallF, e.stall);
      check("StallD", StallD, e.stall);
      check("FlushD", FlushD, e.fd);
      check("FlushE", FlushE, e.fe);
      check("StallCnt", StallCnt, e.sc);
      check("FlushCnt", FlushCnt, e.fc);
    end
  end

  // rst, rs1, rs2, rd, load, pcsrc, regwrite_m, regwrite_w
  int dir_tbl[26][8] = '{
    '{0, 3, 0, 0, 0, 0, 0, 0},  // first instruction after reset: no forward
    '{0, 1, 2, 5, 0, 0, 0, 0},  // add x5
    '{0, 5, 7, 6, 0, 0, 0, 0},  // sub x6,x5,x7
    '{0, 0, 0, 0, 0, 0, 1, 0},  // sub in E, add in M -> forward M on A
    '{0, 1, 2, 5, 0, 0, 0, 0},  // add x5
    '{0, 0, 0, 0, 0, 0, 0, 0},  // bubble
    '{0, 5, 7, 6, 0, 0, 0, 0},  // sub x6,x5,x7
    '{0, 0, 0, 0, 0, 0, 0, 1},  // sub in E, add in W -> forward W on A
    '{0, 0, 0, 5, 0, 0, 0, 0},  // lw x5
    '{0, 0, 5, 8, 1, 0, 0, 0},  // dependent in D, load in E -> stall
    '{0, 0, 5, 8, 0, 0, 0, 0},  // held instruction re-presented, E bubble
    '{0, 0, 0, 0, 0, 0, 0, 1},  // consumer in E, load in W -> forward W on B
    '{0, 1, 1, 9, 0, 0, 0, 0},
    '{0, 2, 3, 4, 0, 1, 0, 0},  // taken branch: flush D and E
    '{0, 9, 9, 0, 0, 0, 1, 1},  // E cleared: nothing to forward
    '{0, 0, 0, 0, 0, 0, 0, 0},  // write x0 into the pipe
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 1, 1},  // x0 in M and W with x0 sources: no forward
    '{0, 0, 3, 4, 1, 0, 0, 0},  // load with RdE=0: no stall
    '{0, 0, 0, 7, 0, 0, 0, 0},  // lw x7
    '{0, 7, 0, 1, 1, 1, 0, 0},  // load-use and branch together
    '{0, 0, 0, 2, 0, 0, 0, 0},  // lw x2
    '{0, 2, 2, 3, 1, 0, 0, 0},  // stall
    '{1, 2, 2, 3, 1, 1, 1, 1},  // reset mid-operation
    '{0, 2, 2, 3, 1, 0, 1, 1},  // after release: no stall, counters cleared
    '{0, 4, 4, 4, 0, 1, 0, 0}
  };

  initial begin
    reset = 1'b1;
    Rs1D = '0; Rs2D = '0; RdD = '0;
    ResultSrcEb0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ex_inst = '{0, 0, 0};
    mem_rd = 0; wb_rd = 0; n_stall = 0; n_flush = 0;

    // Reset with randomized inputs.
    for (int i = 0; i < 3; i++)
      issue(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));

    foreach (dir_tbl[i])
      issue(dir_tbl[i][0], dir_tbl[i][1], dir_tbl[i][2], dir_tbl[i][3],
            dir_tbl[i][4], dir_tbl[i][5], dir_tbl[i][6], dir_tbl[i][7]);

    // Random traffic on a small address space so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      int rst;
      rst = (i >= 300 && i < 302) ? 1 : 0;
      issue(rst, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 9) < 3) ? 1 : 0, ($urandom_range(0, 9) < 2) ? 1 : 0,
            $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // Wait a bounded number of cycles for the monitor to drain the scoreboard.
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
